exec_cluster: RTL and testbench

Parametrised Tomasulo execution cluster: a reservation station of RS_DEPTH entries feeding NUM_FU identical fixed-latency functional units of one kind (add/sub or mul/div). The station snoops the common data bus (CDB) for missing operands and dispatches the oldest ready entry to any free unit. Finished units arbitrate round-robin for a single valid/ready result port that drives the CDB. One instance replaces each hand-coded add/sub or mul/div execute path in the core.

---
 rtl/exec_cluster_if.sv | 42 ++++
 rtl/exec_cluster.sv | 272 +++++++++++++++++++++++++++
 tb/tb_exec_cluster.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_cluster_if.sv
// exec_cluster_if: handshake/bus bundle between the core and one execution cluster.
//   alloc_* : instruction allocation into the reservation station (valid/ready)
//   cdb_*   : common data bus snoop (broadcast, no backpressure)
//   res_*   : result port toward the CDB arbiter (valid/ready)
// master = core side, slave = exec_cluster side.
interface exec_cluster_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [3:0]        alloc_opcode;
  logic [TAG_W-1:0]  alloc_dst_tag;
  logic              alloc_src1_rdy;
  logic              alloc_src2_rdy;
  logic [TAG_W-1:0]  alloc_src1_tag;
  logic [TAG_W-1:0]  alloc_src2_tag;
  logic [DATA_W-1:0] alloc_src1_val;
  logic [DATA_W-1:0] alloc_src2_val;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  logic              res_valid;
  logic              res_ready;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_val;
  logic              res_err;

  modport master (
    output alloc_valid, alloc_opcode, alloc_dst_tag, alloc_src1_rdy, alloc_src2_rdy,
           alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
           cdb_valid, cdb_tag, cdb_val, res_ready,
    input  alloc_ready, res_valid, res_tag, res_val, res_err
  );

  modport slave (
    input  alloc_valid, alloc_opcode, alloc_dst_tag, alloc_src1_rdy, alloc_src2_rdy,
           alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
           cdb_valid, cdb_tag, cdb_val, res_ready,
    output alloc_ready, res_valid, res_tag, res_val, res_err
  );
endinterface

// File: rtl/exec_cluster.sv
// exec_cluster: Tomasulo execution cluster. RS_DEPTH-entry reservation station
// snooping the CDB, dispatching oldest-ready entries to NUM_FU fixed-latency
// units of one kind (FU_KIND 0 = add/sub, 1 = mul/div); finished units share
// one round-robin arbitrated result port.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : squash all entries and in-flight ops
//   bus       : exec_cluster_if.slave (alloc, cdb, res channels)
//   occupancy : number of valid station entries

// One functional unit: loads an op on start, counts LATENCY cycles, then holds
// the result with done=1 until ack.
module exec_fu #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int FU_KIND = 0,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [3:0]        op_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_val,
  output logic              res_err
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic              busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              legal;
  logic [DATA_W-1:0] raw;

  always_comb begin
    busy_d = busy_q; done_d = done_q; cnt_d = cnt_q;
    op_d = op_q; tag_d = tag_q; a_d = a_q; b_d = b_q;
    if (start) begin
      busy_d = 1'b1; done_d = 1'b0; cnt_d = CNT_W'(LATENCY - 1);
      op_d = op_i; tag_d = tag_i; a_d = a_i; b_d = b_i;
    end else if (busy_q && !done_q) begin
      if (cnt_q == '0) done_d = 1'b1;
      else             cnt_d  = cnt_q - 1'b1;
    end else if (done_q && ack) begin
      busy_d = 1'b0; done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q <= 1'b0; done_q <= 1'b0; cnt_q <= '0;
      op_q <= '0; tag_q <= '0; a_q <= '0; b_q <= '0;
    end else begin
      busy_q <= busy_d; done_q <= done_d; cnt_q <= cnt_d;
      op_q <= op_d; tag_q <= tag_d; a_q <= a_d; b_q <= b_d;
    end
  end

  // Operands are frozen while busy, so the result is evaluated combinationally.
  always_comb begin
    legal = (FU_KIND == 0) ? (op_q == 4'd0 || op_q == 4'd1)
                           : (op_q == 4'd2 || op_q == 4'd3);
    case (op_q)
      4'd0:    raw = a_q - b_q;
      4'd1:    raw = a_q + b_q;
      4'd2:    raw = a_q * b_q;
      4'd3:    raw = (b_q == '0) ? '1 : a_q / b_q;
      default: raw = '0;
    endcase
    res_val = legal ? raw : '0;
    res_err = !legal;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign res_tag = tag_q;
endmodule

module exec_cluster #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int RS_DEPTH = 4,
  parameter int NUM_FU   = 2,
  parameter int FU_KIND  = 0,
  parameter int LATENCY  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  exec_cluster_if.slave                   bus,
  output logic [$clog2(RS_DEPTH+1)-1:0]   occupancy
);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  // One extra bit so live sequence stamps never span half the number space.
  localparam int AGE_W = $clog2(RS_DEPTH) + 1;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int OCC_W = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [TAG_W-1:0]  dst;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

  rs_entry_t        rs_q [RS_DEPTH];
  rs_entry_t        rs_d [RS_DEPTH];
  logic [AGE_W-1:0] seq_q, seq_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;

  logic [RS_DEPTH-1:0] elig, taken;
  logic [IDX_W-1:0]    alloc_idx, best;
  logic                alloc_fire, found_e, found_r;

  logic [NUM_FU-1:0]             fu_start, fu_busy, fu_done, fu_ack, fu_err;
  logic [NUM_FU-1:0][IDX_W-1:0]  fu_idx;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_val;
  logic [PTR_W-1:0]              rr_pick, sel;
  logic                          res_vld;

  // Modular age compare: a is older than b when (a - b) is negative.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  // Free flags, lowest free index, eligibility, occupancy: all from registered state.
  always_comb begin
    bus.alloc_ready = 1'b0;
    alloc_idx = '0;
    occupancy = '0;
    elig = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!rs_q[i].valid) begin
        bus.alloc_ready = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      elig[i] = rs_q[i].valid && rs_q[i].s1_rdy && rs_q[i].s2_rdy;
      occupancy = occupancy + OCC_W'(rs_q[i].valid);
    end
  end

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready && !flush;

  // Free units in ascending order each take the oldest eligible untaken entry.
  always_comb begin
    taken = '0; fu_start = '0; fu_idx = '0;
    found_e = 1'b0; best = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      found_e = 1'b0; best = '0;
      if (!fu_busy[k]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (elig[i] && !taken[i] && (!found_e || older(rs_q[i].age, rs_q[best].age))) begin
            found_e = 1'b1;
            best = IDX_W'(i);
          end
        end
        if (found_e) begin
          fu_start[k] = 1'b1;
          fu_idx[k]   = best;
          taken[best] = 1'b1;
        end
      end
    end
  end

  // Station next state: CDB snoop, free dispatched entries, write allocation.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) rs_d[i] = rs_q[i];
    seq_d = seq_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (rs_q[i].valid && bus.cdb_valid) begin
        if (!rs_q[i].s1_rdy && rs_q[i].s1_tag == bus.cdb_tag) begin
          rs_d[i].s1_rdy = 1'b1; rs_d[i].s1_val = bus.cdb_val;
        end
        if (!rs_q[i].s2_rdy && rs_q[i].s2_tag == bus.cdb_tag) begin
          rs_d[i].s2_rdy = 1'b1; rs_d[i].s2_val = bus.cdb_val;
        end
      end
      if (taken[i]) rs_d[i].valid = 1'b0;
    end
    if (alloc_fire) begin
      rs_d[alloc_idx].valid  = 1'b1;
      rs_d[alloc_idx].op     = bus.alloc_opcode;
      rs_d[alloc_idx].dst    = bus.alloc_dst_tag;
      rs_d[alloc_idx].age    = seq_q;
      rs_d[alloc_idx].s1_tag = bus.alloc_src1_tag;
      rs_d[alloc_idx].s2_tag = bus.alloc_src2_tag;
      // Bypass: a source broadcast in the allocation cycle is captured directly.
      rs_d[alloc_idx].s1_rdy = bus.alloc_src1_rdy ||
                               (bus.cdb_valid && bus.cdb_tag == bus.alloc_src1_tag);
      rs_d[alloc_idx].s1_val = bus.alloc_src1_rdy ? bus.alloc_src1_val : bus.cdb_val;
      rs_d[alloc_idx].s2_rdy = bus.alloc_src2_rdy ||
                               (bus.cdb_valid && bus.cdb_tag == bus.alloc_src2_tag);
      rs_d[alloc_idx].s2_val = bus.alloc_src2_rdy ? bus.alloc_src2_val : bus.cdb_val;
      seq_d = seq_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    exec_fu #(.DATA_W(DATA_W), .TAG_W(TAG_W), .FU_KIND(FU_KIND), .LATENCY(LATENCY)) u_fu (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .start   (fu_start[g]),
      .op_i    (rs_q[fu_idx[g]].op),
      .tag_i   (rs_q[fu_idx[g]].dst),
      .a_i     (rs_q[fu_idx[g]].s1_val),
      .b_i     (rs_q[fu_idx[g]].s2_val),
      .ack     (fu_ack[g]),
      .busy    (fu_busy[g]),
      .done    (fu_done[g]),
      .res_tag (fu_tag[g]),
      .res_val (fu_val[g]),
      .res_err (fu_err[g])
    );
  end

  // Round-robin grant; once offered and stalled the grant is locked so a
  // later-finishing unit at higher priority cannot change res_* mid-stall.
  always_comb begin
    rr_pick = rr_q; found_r = 1'b0;
    for (int off = 0; off < NUM_FU; off++) begin
      if (!found_r && fu_done[(int'(rr_q) + off) % NUM_FU]) begin
        found_r = 1'b1;
        rr_pick = PTR_W'((int'(rr_q) + off) % NUM_FU);
      end
    end
    sel     = lock_q ? lock_idx_q : rr_pick;
    res_vld = |fu_done;
    bus.res_valid = res_vld;
    bus.res_tag   = res_vld ? fu_tag[sel] : '0;
    bus.res_val   = res_vld ? fu_val[sel] : '0;
    bus.res_err   = res_vld ? fu_err[sel] : 1'b0;
    fu_ack = '0;
    rr_d = rr_q;
    if (res_vld && bus.res_ready) begin
      fu_ack[sel] = 1'b1;
      rr_d = (int'(sel) == NUM_FU - 1) ? '0 : sel + 1'b1;
    end
    lock_d     = res_vld && !bus.res_ready;
    lock_idx_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= '0;
      seq_q <= '0; rr_q <= '0; lock_q <= 1'b0; lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= rs_d[i];
      seq_q <= seq_d; rr_q <= rr_d; lock_q <= lock_d; lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_exec_cluster.sv
// Bench for exec_cluster: dut0 is add/sub (LATENCY 3), dut1 is mul/div (LATENCY 7).
// Expected results are queued at stimulus time and popped on each accepted result.
module tb_exec_cluster;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush0 = 1'b0, flush1 = 1'b0;
  logic [2:0] occ0, occ1;
  int n_chk = 0, n_fail = 0;

  typedef struct { logic [3:0] tag; logic [31:0] val; logic err; } exp_t;
  exp_t q0[$], q1[$];

  exec_cluster_if #(.DATA_W(32), .TAG_W(4)) if0 ();
  exec_cluster_if #(.DATA_W(32), .TAG_W(4)) if1 ();

  exec_cluster #(.DATA_W(32), .TAG_W(4), .RS_DEPTH(4), .NUM_FU(2), .FU_KIND(0), .LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(if0.slave), .occupancy(occ0));
  exec_cluster #(.DATA_W(32), .TAG_W(4), .RS_DEPTH(4), .NUM_FU(2), .FU_KIND(1), .LATENCY(7)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(if1.slave), .occupancy(occ1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic alloc0(input logic [3:0] op, input logic [3:0] dst,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2);
    if0.alloc_valid = 1'b1; if0.alloc_opcode = op; if0.alloc_dst_tag = dst;
    if0.alloc_src1_rdy = r1; if0.alloc_src1_tag = t1; if0.alloc_src1_val = v1;
    if0.alloc_src2_rdy = r2; if0.alloc_src2_tag = t2; if0.alloc_src2_val = v2;
    tick();
    if0.alloc_valid = 1'b0;
  endtask

  task automatic alloc1(input logic [3:0] op, input logic [3:0] dst,
                        input logic [31:0] v1, input logic [31:0] v2);
    if1.alloc_valid = 1'b1; if1.alloc_opcode = op; if1.alloc_dst_tag = dst;
    if1.alloc_src1_rdy = 1'b1; if1.alloc_src1_tag = 4'd0; if1.alloc_src1_val = v1;
    if1.alloc_src2_rdy = 1'b1; if1.alloc_src2_tag = 4'd0; if1.alloc_src2_val = v2;
    tick();
    if1.alloc_valid = 1'b0;
  endtask

  task automatic cdb0(input logic [3:0] tag, input logic [31:0] val);
    if0.cdb_valid = 1'b1; if0.cdb_tag = tag; if0.cdb_val = val;
    tick();
    if0.cdb_valid = 1'b0;
  endtask

  task automatic take0(input string nm);
    exp_t e;
    int n = 0;
    while (!if0.res_valid && n < 40) begin tick(); n++; end
    chk({nm, " res_valid"}, if0.res_valid, 1);
    chk({nm, " sb nonempty"}, q0.size() > 0, 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({nm, " res_tag"}, if0.res_tag, e.tag);
      chk({nm, " res_val"}, if0.res_val, e.val);
      chk({nm, " res_err"}, if0.res_err, e.err);
    end
    if0.res_ready = 1'b1; tick(); if0.res_ready = 1'b0;
  endtask

  task automatic take1(input string nm);
    exp_t e;
    int n = 0;
    while (!if1.res_valid && n < 40) begin tick(); n++; end
    chk({nm, " res_valid"}, if1.res_valid, 1);
    chk({nm, " sb nonempty"}, q1.size() > 0, 1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({nm, " res_tag"}, if1.res_tag, e.tag);
      chk({nm, " res_val"}, if1.res_val, e.val);
      chk({nm, " res_err"}, if1.res_err, e.err);
    end
    if1.res_ready = 1'b1; tick(); if1.res_ready = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    if0.alloc_valid = 0; if0.alloc_opcode = 0; if0.alloc_dst_tag = 0;
    if0.alloc_src1_rdy = 0; if0.alloc_src1_tag = 0; if0.alloc_src1_val = 0;
    if0.alloc_src2_rdy = 0; if0.alloc_src2_tag = 0; if0.alloc_src2_val = 0;
    if0.cdb_valid = 0; if0.cdb_tag = 0; if0.cdb_val = 0; if0.res_ready = 0;
    if1.alloc_valid = 0; if1.alloc_opcode = 0; if1.alloc_dst_tag = 0;
    if1.alloc_src1_rdy = 0; if1.alloc_src1_tag = 0; if1.alloc_src1_val = 0;
    if1.alloc_src2_rdy = 0; if1.alloc_src2_tag = 0; if1.alloc_src2_val = 0;
    if1.cdb_valid = 0; if1.cdb_tag = 0; if1.cdb_val = 0; if1.res_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst alloc_ready", if0.alloc_ready, 1);
    chk("rst res_valid", if0.res_valid, 0);
    chk("rst res_tag", if0.res_tag, 0);
    chk("rst res_val", if0.res_val, 0);
    chk("rst res_err", if0.res_err, 0);
    chk("rst occupancy", occ0, 0);
    chk("rst1 alloc_ready", if1.alloc_ready, 1);
    chk("rst1 res_valid", if1.res_valid, 0);
    chk("rst1 occupancy", occ1, 0);
    rst = 1'b0;

    // Add 5+7, both ready: result offered after edge E+1+LATENCY
    q0.push_back('{4'd3, 32'd12, 1'b0});
    alloc0(4'd1, 4'd3, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7);
    chk("add occupancy", occ0, 1);
    tick(); tick(); tick();
    chk("add not early", if0.res_valid, 0);
    tick();
    chk("add latency", if0.res_valid, 1);
    take0("add");

    // Dependency: src1 waits on tag 9; unrelated tag 7 ignored
    q0.push_back('{4'd5, 32'd6, 1'b0});
    alloc0(4'd0, 4'd5, 0, 4'd9, 32'd0, 1, 4'd0, 32'd4);
    cdb0(4'd7, 32'd99);
    chk("dep unrelated ignored", occ0, 1);
    cdb0(4'd9, 32'd10);
    chk("dep captured not yet dispatched", occ0, 1);
    tick();
    chk("dep dispatched", occ0, 0);
    take0("dep sub");

    // Fill the station with waiting entries
    alloc0(4'd1, 4'd1, 0, 4'd10, 32'd0, 1, 4'd0, 32'd1);
    alloc0(4'd1, 4'd2, 0, 4'd11, 32'd0, 1, 4'd0, 32'd1);
    alloc0(4'd1, 4'd3, 0, 4'd12, 32'd0, 1, 4'd0, 32'd1);
    alloc0(4'd1, 4'd4, 0, 4'd13, 32'd0, 1, 4'd0, 32'd1);
    chk("full alloc_ready", if0.alloc_ready, 0);
    chk("full occupancy", occ0, 4);
    cdb0(4'd12, 32'd20);
    chk("full still resident", if0.alloc_ready, 0);
    cdb0(4'd10, 32'd30);
    chk("entry2 freed alloc_ready", if0.alloc_ready, 1);
    chk("entry2 freed occupancy", occ0, 3);
    tick();
    chk("second dispatch occupancy", occ0, 2);

    // Flush with two ops in flight, two pending, and a concurrent alloc
    flush0 = 1'b1;
    if0.alloc_valid = 1'b1; if0.alloc_src1_rdy = 1; if0.alloc_src2_rdy = 1;
    tick();
    flush0 = 1'b0; if0.alloc_valid = 1'b0;
    chk("flush res_valid", if0.res_valid, 0);
    chk("flush occupancy", occ0, 0);
    chk("flush alloc_ready", if0.alloc_ready, 1);
    chk("flush res_tag", if0.res_tag, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if0.res_valid) seen++;
    end
    chk("flush no stale result", seen, 0);
    chk("flush alloc discarded", occ0, 0);

    // Two results complete together; stall 3 cycles, then unit 0 then unit 1
    q0.push_back('{4'd6, 32'd150, 1'b0});
    q0.push_back('{4'd7, 32'd49, 1'b0});
    alloc0(4'd1, 4'd6, 0, 4'd14, 32'd0, 1, 4'd0, 32'd100);
    alloc0(4'd0, 4'd7, 0, 4'd14, 32'd0, 1, 4'd0, 32'd1);
    cdb0(4'd14, 32'd50);
    n = 0;
    while (!if0.res_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("stall res_valid", if0.res_valid, 1);
      chk("stall res_tag", if0.res_tag, 6);
      chk("stall res_val", if0.res_val, 150);
      tick();
    end
    take0("pair first");
    take0("pair second");

    // Rotation: single op moves pointer to 1, next pair grants unit 1 first
    q0.push_back('{4'd8, 32'd3, 1'b0});
    alloc0(4'd1, 4'd8, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
    take0("rr single");
    q0.push_back('{4'd10, 32'd25, 1'b0});
    q0.push_back('{4'd9, 32'd15, 1'b0});
    alloc0(4'd1, 4'd9, 0, 4'd15, 32'd0, 1, 4'd0, 32'd10);
    alloc0(4'd1, 4'd10, 0, 4'd15, 32'd0, 1, 4'd0, 32'd20);
    cdb0(4'd15, 32'd5);
    take0("rr unit1 first");
    take0("rr unit0 second");

    // mul/div cluster, LATENCY 7
    q1.push_back('{4'd1, 32'd14, 1'b0});
    q1.push_back('{4'd2, 32'hFFFF_FFFF, 1'b0});
    q1.push_back('{4'd3, 32'hFFFF_FFFE, 1'b0});
    q1.push_back('{4'd4, 32'd0, 1'b1});
    alloc1(4'd3, 4'd1, 32'd100, 32'd7);
    alloc1(4'd3, 4'd2, 32'd5, 32'd0);
    alloc1(4'd2, 4'd3, 32'hFFFF_FFFF, 32'd2);
    alloc1(4'd1, 4'd4, 32'd3, 32'd4);
    tick(); tick(); tick(); tick();
    chk("div not early", if1.res_valid, 0);
    tick();
    chk("div latency", if1.res_valid, 1);
    take1("div 100/7");
    take1("div by zero");
    take1("mul wrap");
    take1("illegal add");
    chk("md drained occupancy", occ1, 0);
    chk("sb0 empty", q0.size(), 0);
    chk("sb1 empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
